// File: rtl/axi_wdata_router_pkg.sv
// Shared definitions for the AXI write-data router.
// - Slave select encoding produced by the AW decoder and consumed by the W router.
// - route_t: one accepted AW route {sel, len} held until its W burst completes.
package axi_wdata_router_pkg;

  localparam int unsigned AXI_LEN_BITS  = 4;
  localparam int unsigned AXI_DATA_BITS = 32;

  localparam logic [1:0] SEL_S0 = 2'b00;
  localparam logic [1:0] SEL_S1 = 2'b01;
  localparam logic [1:0] SEL_SD = 2'b10;  // 2'b11 also decodes to the default slave

  typedef struct packed {
    logic [1:0]              sel;
    logic [AXI_LEN_BITS-1:0] len;
  } route_t;

endpackage

// File: rtl/axi_wdata_router_route_fifo.sv
// Synchronous FIFO of AW routes.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   push_i, entry_i   enqueue a route (ignored when full)
//   pop_i             dequeue the head (ignored when empty)
//   full_o, empty_o   occupancy flags
//   head_o            oldest route, valid when !empty_o
module axi_wdata_router_route_fifo
  import axi_wdata_router_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  route_t entry_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output route_t head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(Depth);

  route_t          mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  logic            push_en, pop_en;

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_en && !pop_en)      cnt_q <= cnt_q + (PtrW + 1)'(1);
      else if (!push_en && pop_en) cnt_q <= cnt_q - (PtrW + 1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/axi_wdata_router.sv
// AXI write-data router: steers one master's W beats to S0, S1 or the default
// slave SD in the order AW transfers were accepted, and regenerates WLAST.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   aw_fire_i/aw_sel_i/aw_len_i  accepted AW: target select and AWLEN
//   aw_route_ready_o             route queue has space (gates AWREADY upstream)
//   W*_M1                        master W channel
//   W*_S0 / W*_S1 / W*_SD        slave W channels
//   wlast_err_o                  one-cycle pulse when master WLAST disagrees with beat count
module axi_wdata_router
  import axi_wdata_router_pkg::*;
#(
  parameter int unsigned ROUTE_DEPTH = 2,
  parameter int unsigned LEN_W       = AXI_LEN_BITS,
  parameter int unsigned DATA_W      = AXI_DATA_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                aw_fire_i,
  input  logic [1:0]          aw_sel_i,
  input  logic [LEN_W-1:0]    aw_len_i,
  output logic                aw_route_ready_o,
  input  logic [DATA_W-1:0]   WDATA_M1,
  input  logic [DATA_W/8-1:0] WSTRB_M1,
  input  logic                WLAST_M1,
  input  logic                WVALID_M1,
  output logic                WREADY_M1,
  output logic [DATA_W-1:0]   WDATA_S0,
  output logic [DATA_W/8-1:0] WSTRB_S0,
  output logic                WLAST_S0,
  output logic                WVALID_S0,
  input  logic                WREADY_S0,
  output logic [DATA_W-1:0]   WDATA_S1,
  output logic [DATA_W/8-1:0] WSTRB_S1,
  output logic                WLAST_S1,
  output logic                WVALID_S1,
  input  logic                WREADY_S1,
  output logic [DATA_W-1:0]   WDATA_SD,
  output logic [DATA_W/8-1:0] WSTRB_SD,
  output logic                WLAST_SD,
  output logic                WVALID_SD,
  input  logic                WREADY_SD,
  output logic                wlast_err_o
);

  route_t             head;
  logic               q_empty, q_full;
  logic               at_last, fire, pop;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               err_q, err_d;

  axi_wdata_router_route_fifo #(
    .Depth (ROUTE_DEPTH)
  ) u_route_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (aw_fire_i),
    .entry_i ('{sel: aw_sel_i, len: aw_len_i}),
    .pop_i   (pop),
    .full_o  (q_full),
    .empty_o (q_empty),
    .head_o  (head)
  );

  assign aw_route_ready_o = ~q_full;

  assign at_last = ~q_empty & (beat_cnt_q == head.len);

  // Steering from the queue head; an empty queue stalls the master.
  always_comb begin
    WVALID_S0 = 1'b0;
    WVALID_S1 = 1'b0;
    WVALID_SD = 1'b0;
    WREADY_M1 = 1'b0;
    if (!q_empty) begin
      case (head.sel)
        SEL_S0: begin
          WVALID_S0 = WVALID_M1;
          WREADY_M1 = WREADY_S0;
        end
        SEL_S1: begin
          WVALID_S1 = WVALID_M1;
          WREADY_M1 = WREADY_S1;
        end
        default: begin
          WVALID_SD = WVALID_M1;
          WREADY_M1 = WREADY_SD;
        end
      endcase
    end
  end

  assign WDATA_S0 = WDATA_M1;
  assign WDATA_S1 = WDATA_M1;
  assign WDATA_SD = WDATA_M1;
  assign WSTRB_S0 = WSTRB_M1;
  assign WSTRB_S1 = WSTRB_M1;
  assign WSTRB_SD = WSTRB_M1;

  // Slave WLAST comes from the beat count, never from the master.
  assign WLAST_S0 = at_last;
  assign WLAST_S1 = at_last;
  assign WLAST_SD = at_last;

  assign fire = WVALID_M1 & WREADY_M1;
  assign pop  = fire & at_last;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (fire) begin
      beat_cnt_d = at_last ? '0 : beat_cnt_q + LEN_W'(1);
    end
    err_d = fire & (WLAST_M1 != at_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

  assign wlast_err_o = err_q;

endmodule

// File: tb/tb_axi_wdata_router.sv
// Randomized bench for axi_wdata_router against a queue-based reference model.
module tb_axi_wdata_router;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int          NCYC   = 2500;

  logic                clk = 1'b0;
  logic                rst;
  logic                aw_fire_i;
  logic [1:0]          aw_sel_i;
  logic [LEN_W-1:0]    aw_len_i;
  logic                aw_route_ready_o;
  logic [DATA_W-1:0]   WDATA_M1;
  logic [DATA_W/8-1:0] WSTRB_M1;
  logic                WLAST_M1, WVALID_M1, WREADY_M1;
  logic [DATA_W-1:0]   WDATA_S0, WDATA_S1, WDATA_SD;
  logic [DATA_W/8-1:0] WSTRB_S0, WSTRB_S1, WSTRB_SD;
  logic                WLAST_S0, WLAST_S1, WLAST_SD;
  logic                WVALID_S0, WVALID_S1, WVALID_SD;
  logic                WREADY_S0, WREADY_S1, WREADY_SD;
  logic                wlast_err_o;

  always #5 clk = ~clk;

  axi_wdata_router #(
    .ROUTE_DEPTH (DEPTH),
    .LEN_W       (LEN_W),
    .DATA_W      (DATA_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .aw_fire_i        (aw_fire_i),
    .aw_sel_i         (aw_sel_i),
    .aw_len_i         (aw_len_i),
    .aw_route_ready_o (aw_route_ready_o),
    .WDATA_M1         (WDATA_M1),
    .WSTRB_M1         (WSTRB_M1),
    .WLAST_M1         (WLAST_M1),
    .WVALID_M1        (WVALID_M1),
    .WREADY_M1        (WREADY_M1),
    .WDATA_S0         (WDATA_S0),
    .WSTRB_S0         (WSTRB_S0),
    .WLAST_S0         (WLAST_S0),
    .WVALID_S0        (WVALID_S0),
    .WREADY_S0        (WREADY_S0),
    .WDATA_S1         (WDATA_S1),
    .WSTRB_S1         (WSTRB_S1),
    .WLAST_S1         (WLAST_S1),
    .WVALID_S1        (WVALID_S1),
    .WREADY_S1        (WREADY_S1),
    .WDATA_SD         (WDATA_SD),
    .WSTRB_SD         (WSTRB_SD),
    .WLAST_SD         (WLAST_SD),
    .WVALID_SD        (WVALID_SD),
    .WREADY_SD        (WREADY_SD),
    .wlast_err_o      (wlast_err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: pending routes as {sel, len}, beats done in the head burst.
  logic [5:0] rq[$];
  int         done_beats;
  bit         err_pend;

  initial begin
    int  tgt, hlen;
    bit  nonempty, exp_last, exp_ready, fire;
    bit  [2:0] rdy;
    done_beats = 0;
    err_pend   = 1'b0;
    rst        = 1'b1;
    aw_fire_i  = 1'b0;
    aw_sel_i   = '0;
    aw_len_i   = '0;
    WDATA_M1   = '0;
    WSTRB_M1   = '0;
    WLAST_M1   = 1'b0;
    WVALID_M1  = 1'b0;
    WREADY_S0  = 1'b0;
    WREADY_S1  = 1'b0;
    WREADY_SD  = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      nonempty = (rq.size() > 0);
      tgt      = nonempty ? ((rq[0][5:4] == 2'd0) ? 0 : (rq[0][5:4] == 2'd1) ? 1 : 2) : 0;
      hlen     = nonempty ? int'(rq[0][3:0]) : 0;
      exp_last = nonempty && (done_beats == hlen);

      rst       = (cyc < 2) || ($urandom_range(0, 199) == 0);
      if (rq.size() < DEPTH) aw_fire_i = ($urandom_range(0, 2) == 0);
      else                   aw_fire_i = ($urandom_range(0, 9) == 0);
      aw_sel_i  = 2'($urandom_range(0, 3));
      aw_len_i  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                              : 4'($urandom_range(0, 3));
      WDATA_M1  = $urandom;
      WSTRB_M1  = 4'($urandom_range(0, 15));
      WVALID_M1 = ($urandom_range(0, 9) < 7);
      WLAST_M1  = exp_last ^ ($urandom_range(0, 9) == 0);
      rdy       = 3'($urandom_range(0, 7)) | 3'(($urandom_range(0, 1) == 0) ? 7 : 0);
      WREADY_S0 = rdy[0];
      WREADY_S1 = rdy[1];
      WREADY_SD = rdy[2];

      exp_ready = nonempty && rdy[tgt];
      fire      = exp_ready && WVALID_M1;

      #1;
      check_eq("aw_route_ready", aw_route_ready_o, rq.size() < DEPTH);
      check_eq("wready_m1", WREADY_M1, exp_ready);
      check_eq("wvalid_s0", WVALID_S0, nonempty && tgt == 0 && WVALID_M1);
      check_eq("wvalid_s1", WVALID_S1, nonempty && tgt == 1 && WVALID_M1);
      check_eq("wvalid_sd", WVALID_SD, nonempty && tgt == 2 && WVALID_M1);
      check_eq("wlast_s0", WLAST_S0, exp_last);
      check_eq("wlast_s1", WLAST_S1, exp_last);
      check_eq("wlast_sd", WLAST_SD, exp_last);
      check_eq("wlast_err", wlast_err_o, err_pend);
      check_eq("wdata_bcast", {WDATA_S0, WDATA_S1}, {WDATA_M1, WDATA_M1});
      check_eq("wdata_sd", WDATA_SD, WDATA_M1);
      check_eq("wstrb_bcast", {WSTRB_S0, WSTRB_S1, WSTRB_SD}, {3{WSTRB_M1}});

      @(posedge clk);
      if (rst) begin
        rq.delete();
        done_beats = 0;
        err_pend   = 1'b0;
      end else begin
        bit was_full;
        was_full = (rq.size() >= DEPTH);
        err_pend = fire && (WLAST_M1 != exp_last);
        if (fire) begin
          if (exp_last) begin
            void'(rq.pop_front());
            done_beats = 0;
          end else begin
            done_beats++;
          end
        end
        if (aw_fire_i && !was_full) rq.push_back({aw_sel_i, aw_len_i});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_wdata_router.md
Name: axi_wdata_router

Overview:
- Write-data (W) channel stage sitting directly downstream of the write-address router.
- Consumes each accepted AW transfer (target slave select + AWLEN) into a small route queue.
- Steers M1's W beats to S0, S1 or the default slave SD in AW order, counting beats and generating the slave-side WLAST.
- Flags master WLAST that disagrees with the beat count.

Parameters:
- ROUTE_DEPTH, 2, number of accepted-but-unfinished AW routes held; power of two, >=2.
- LEN_W, `AXI_LEN_BITS (4), width of the AWLEN / beat counter.
- DATA_W, `AXI_DATA_BITS (32), W data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- aw_fire_i  in  1  AW handshake completed this cycle (AWVALID & AWREADY at the AW router)
- aw_sel_i  in  2  target of that AW: 00 = S0, 01 = S1, 10/11 = SD
- aw_len_i  in  LEN_W  AWLEN of that AW (beats - 1)
- aw_route_ready_o  out  1  route queue not full; AW router ANDs this into AWREADY
- WDATA_M1  in  DATA_W  master write data
- WSTRB_M1  in  DATA_W/8  master strobes
- WLAST_M1  in  1  master last flag
- WVALID_M1  in  1  master valid
- WREADY_M1  out  1  ready to master
- WDATA_Sx, WSTRB_Sx, WLAST_Sx, WVALID_Sx  out  (DATA_W, DATA_W/8, 1, 1)  to slave x, for x in {S0, S1, SD}
- WREADY_Sx  in  1  from slave x, for x in {S0, S1, SD}
- wlast_err_o  out  1  one-cycle pulse on master WLAST mismatch

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - Queue emptied; beat counter = 0; wlast_err_o = 0.
  - After reset: aw_route_ready_o = 1; WREADY_M1 = 0; all WVALID_Sx = 0.
  - Reset mid-burst abandons the burst with no further beats; the testbench also resets the slaves.
- Route queue: FIFO of {sel, len}, ROUTE_DEPTH entries.
  - Push on aw_fire_i.
  - aw_fire_i while full is a protocol violation and is ignored; it cannot occur when AWREADY honours aw_route_ready_o.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
- Latency: a route pushed at edge N is usable from cycle N+1. There is no bypass, so W is never steered in the cycle of its own AW fire.
- Steering (combinational, from queue head, only when the queue is not empty):
  - WVALID_Ssel = WVALID_M1; the other WVALID_Sx = 0.
  - WREADY_M1 = WREADY_Ssel.
  - Empty queue: WREADY_M1 = 0 and all WVALID_Sx = 0; master beats stall.
- Data fan-out: WDATA, WSTRB broadcast unconditionally to all three slaves.
- Beat fire = WVALID_M1 & WREADY_M1.
  - On fire: if beat_cnt == head.len, pop the head and set beat_cnt = 0; otherwise beat_cnt += 1.
  - The counter is LEN_W bits and never wraps, because the pop happens at len.
- WLAST_Sx = (beat_cnt == head.len) when the queue is not empty; master WLAST_M1 is not forwarded.
- Error check: on fire, if WLAST_M1 != (beat_cnt == head.len), wlast_err_o = 1 in the following cycle. Routing continues on the counter, not on WLAST_M1.
- Back-to-back bursts: the last beat of burst A and the first beat of burst B may fire on consecutive cycles, with no bubble.
- A WVALID_Sx, once asserted, stays stable until WREADY_Sx because the master holds WVALID; the router adds no extra holding.

Decomposition:
- Shared package / AXI_define: slave select encoding (SEL_S0 = 2'b00, SEL_S1 = 2'b01, SEL_SD = 2'b10) and a packed route_t {sel, len} typedef.
- Reuse these encodings in the AW decoder so aw_sel_i is produced directly.
- One natural sub-module: route_fifo (parameterised sync FIFO of route_t: push, pop, full, empty, head).
- Counter and steering stay in the top module.

Test Plan:
- Single beat to S0: AW sel=00 len=0. Next cycle WVALID_M1=1, WLAST_M1=1, WREADY_S0=1 → WVALID_S0=1, WLAST_S0=1, WVALID_S1=WVALID_SD=0; queue empty afterwards; wlast_err_o stays 0.
- 4-beat burst to S1 with backpressure: sel=01 len=3, WREADY_S1 low on beat 2 for 2 cycles → WREADY_M1 low for those 2 cycles; WLAST_S1 only on beat 4; exactly 4 fires.
- Two queued routes: AW to SD (len=1), then to S0 (len=0), before any W. aw_route_ready_o = 0 after 2nd push. 3 W beats → 2 to SD then 1 to S0 with no bubble; ready returns to 1 after the first pop.
- W before AW: WVALID_M1=1 with empty queue for 3 cycles → WREADY_M1=0 and no slave WVALID; beat accepted only the cycle after aw_fire_i.
- WLAST mismatch: len=1, master asserts WLAST_M1 on beat 1 → wlast_err_o = 1 for one cycle; beat 2 still routed with WLAST_S0 = 1; queue empty at end.
- Mid-burst reset: len=7, rst after 3 beats → next cycle WREADY_M1=0, aw_route_ready_o=1, beat_cnt=0. A new len=0 burst then completes in 1 beat.
